// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit
// four-register CPU. Fetches instruction bytes over a req/valid handshake,
// drives the register-file addresses and write strobe, selects the external
// ALU operation, and holds the program counter and the Z/C flags.
module cpu_control_unit #(
    parameter int unsigned         PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [7:0]          imem_data,
    output logic [1:0]          rf_read_addr_s,
    output logic [1:0]          rf_read_addr_d,
    output logic [1:0]          rf_write_addr_d,
    output logic                rf_write_enable,
    output logic [7:0]          rf_write_data,
    output logic [2:0]          alu_op,
    input  logic [7:0]          alu_result,
    input  logic                alu_zero,
    input  logic                alu_carry,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_MOV    = 4'h1,
        OP_ADD    = 4'h2,
        OP_SUB    = 4'h3,
        OP_AND    = 4'h4,
        OP_OR     = 4'h5,
        OP_XOR    = 4'h6,
        OP_NOT    = 4'h7,
        OP_CMP    = 4'h8,
        OP_LDI    = 4'h9,
        OP_JMP    = 4'hA,
        OP_JZ     = 4'hB,
        OP_JC     = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_HALT   = 4'hF
    } opcode_e;

    // ALU operation codes seen by the external combinational ALU
    localparam logic [2:0] ALU_PASS_S = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;
    localparam logic [2:0] ALU_XOR    = 3'd5;
    localparam logic [2:0] ALU_NOT_S  = 3'd6;

    state_e              state;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          ir;
    logic [7:0]          imm;
    logic [7:0]          result;
    logic                flag_z;
    logic                flag_c;
    opcode_e             opcode;

    assign opcode          = opcode_e'(ir[7:4]);
    assign imem_addr       = pc;
    assign rf_read_addr_s  = ir[1:0];
    assign rf_read_addr_d  = ir[3:2];
    assign rf_write_addr_d = ir[3:2];
    assign rf_write_data   = result;

    function automatic logic [2:0] alu_sel(input opcode_e op);
        case (op)
            OP_MOV:  alu_sel = ALU_PASS_S;
            OP_ADD:  alu_sel = ALU_ADD;
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            OP_XOR:  alu_sel = ALU_XOR;
            OP_NOT:  alu_sel = ALU_NOT_S;
            OP_CMP:  alu_sel = ALU_SUB;
            default: alu_sel = ALU_PASS_S;
        endcase
    endfunction

    // Sequencer: state, architectural registers and all registered outputs.
    // imem_req is set on every transition into a fetch state so it is already
    // high during the first fetch cycle; alu_op is selected on leaving DECODE
    // so it is stable for the whole EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            ir              <= '0;
            imm             <= '0;
            result          <= '0;
            flag_z          <= 1'b0;
            flag_c          <= 1'b0;
            imem_req        <= 1'b0;
            rf_write_enable <= 1'b0;
            alu_op          <= '0;
            halted          <= 1'b0;
        end else begin
            rf_write_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_data;
                        pc       <= pc + PC_WIDTH'(1);
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op <= alu_sel(opcode);
                    case (opcode)
                        OP_NOP, OP_RSVD_D, OP_RSVD_E: begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        OP_LDI, OP_JMP, OP_JZ, OP_JC: begin
                            state    <= S_FETCH_IMM;
                            imem_req <= 1'b1;
                        end
                        default: state <= S_EXEC;
                    endcase
                end
                S_FETCH_IMM: begin
                    if (imem_valid) begin
                        imm      <= imem_data;
                        pc       <= pc + PC_WIDTH'(1);
                        imem_req <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_MOV: begin
                            result          <= alu_result;
                            rf_write_enable <= 1'b1;
                            state           <= S_WB;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                            result          <= alu_result;
                            flag_z          <= alu_zero;
                            flag_c          <= alu_carry;
                            rf_write_enable <= 1'b1;
                            state           <= S_WB;
                        end
                        OP_CMP: begin
                            result   <= alu_result;
                            flag_z   <= alu_zero;
                            flag_c   <= alu_carry;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_LDI: begin
                            result          <= imm;
                            rf_write_enable <= 1'b1;
                            state           <= S_WB;
                        end
                        OP_JMP: begin
                            pc       <= PC_WIDTH'(imm);
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_JZ: begin
                            if (flag_z) pc <= PC_WIDTH'(imm);
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_JC: begin
                            if (flag_c) pc <= PC_WIDTH'(imm);
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        default: begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_WB: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    imem_req <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed program run against cpu_control_unit with a
// behavioural register file, ALU and instruction memory around it. Expected
// fetch addresses and register writes are queued up front; a negedge monitor
// pops and compares whenever the DUT completes a fetch or strobes a write.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [1:0] rf_read_addr_s;
    logic [1:0] rf_read_addr_d;
    logic [1:0] rf_write_addr_d;
    logic       rf_write_enable;
    logic [7:0] rf_write_data;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       halted;

    cpu_control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_data       (imem_data),
        .rf_read_addr_s  (rf_read_addr_s),
        .rf_read_addr_d  (rf_read_addr_d),
        .rf_write_addr_d (rf_write_addr_d),
        .rf_write_enable (rf_write_enable),
        .rf_write_data   (rf_write_data),
        .alu_op          (alu_op),
        .alu_result      (alu_result),
        .alu_zero        (alu_zero),
        .alu_carry       (alu_carry),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Register file and ALU environment
    logic [7:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    always @(posedge clk) begin
        if (rf_write_enable) regs[rf_write_addr_d] <= rf_write_data;
    end

    logic [7:0] rd_val, rs_val;
    logic [8:0] wide;
    always_comb begin
        rd_val    = regs[rf_read_addr_d];
        rs_val    = regs[rf_read_addr_s];
        wide      = 9'd0;
        alu_carry = 1'b0;
        case (alu_op)
            3'd0: alu_result = rs_val;
            3'd1: begin wide = {1'b0, rd_val} + {1'b0, rs_val}; alu_result = wide[7:0]; alu_carry = wide[8]; end
            3'd2: begin alu_result = rd_val - rs_val; alu_carry = (rd_val < rs_val); end
            3'd3: alu_result = rd_val & rs_val;
            3'd4: alu_result = rd_val | rs_val;
            3'd5: alu_result = rd_val ^ rs_val;
            3'd6: alu_result = ~rs_val;
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    // Instruction memory: zero-wait except a 3-cycle stall on the first
    // request to 0x70; drives junk with valid high while no request is open.
    // Once 0xFF has been served, address 0x00 returns HALT.
    logic [7:0] mem [256];
    logic       mem_en = 1'b0;
    int         stall_cnt = 0;
    bit         stall_done = 1'b0;
    bit         seen_ff = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!mem_en) begin
            imem_valid = 1'b0;
        end else if (!stall_done && (stall_cnt > 0 || (imem_req && imem_addr == 8'h70))) begin
            imem_valid = 1'b0;
            chk("stall_req_held", imem_req, 1'b1);
            chk("stall_addr_stable", imem_addr, 8'h70);
            stall_cnt++;
            if (stall_cnt == 3) stall_done = 1'b1;
        end else if (!imem_req) begin
            imem_valid = 1'b1;
            imem_data  = 8'hA5;
        end else begin
            imem_valid = 1'b1;
            imem_data  = (imem_addr == 8'h00 && seen_ff) ? 8'hF0 : mem[imem_addr];
            if (imem_addr == 8'hFF) seen_ff = 1'b1;
        end
    end

    // Scoreboard
    logic [7:0] exp_fetch [$];
    logic [9:0] exp_wr [$];

    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            if (imem_req && imem_valid) begin
                if (exp_fetch.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fetch_extra: got fetch at 0x%0h expected none", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, exp_fetch.pop_front());
                end
            end
            if (rf_write_enable) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write_extra: got R%0d<=0x%0h expected none", rf_write_addr_d, rf_write_data);
                end else begin
                    chk("rf_write", {rf_write_addr_d, rf_write_data}, exp_wr.pop_front());
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_imem_req"}, imem_req, 1'b0);
        chk({tag, "_imem_addr"}, imem_addr, 8'h00);
        chk({tag, "_rf_we"}, rf_write_enable, 1'b0);
        chk({tag, "_rf_wdata"}, rf_write_data, 8'h00);
        chk({tag, "_alu_op"}, alu_op, 3'd0);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_rf_addrs"}, {rf_read_addr_s, rf_read_addr_d, rf_write_addr_d}, 6'd0);
    endtask

    initial begin
        bit done;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // 00 LDI R1,05 / 02 LDI R2,03 / 04 ADD R1,R2 / 05 JZ 80 / 07 JC 80
        mem[8'h00] = 8'h94; mem[8'h01] = 8'h05;
        mem[8'h02] = 8'h98; mem[8'h03] = 8'h03;
        mem[8'h04] = 8'h26;
        mem[8'h05] = 8'hB0; mem[8'h06] = 8'h80;
        mem[8'h07] = 8'hC0; mem[8'h08] = 8'h80;
        // 09 LDI R0,FF / 0B LDI R3,01 / 0D ADD R0,R3 / 0E JZ 40
        mem[8'h09] = 8'h90; mem[8'h0A] = 8'hFF;
        mem[8'h0B] = 8'h9C; mem[8'h0C] = 8'h01;
        mem[8'h0D] = 8'h23;
        mem[8'h0E] = 8'hB0; mem[8'h0F] = 8'h40;
        // 40 CMP R1,R1 / 41 JC 80 / 43 JZ 50
        mem[8'h40] = 8'h85;
        mem[8'h41] = 8'hC0; mem[8'h42] = 8'h80;
        mem[8'h43] = 8'hB0; mem[8'h44] = 8'h50;
        // 50 SUB R1,R2 / MOV R3,R1 / NOT R2,R1 / XOR R2,R2 / MOV R0,R1 / D0 / JZ 60
        mem[8'h50] = 8'h36; mem[8'h51] = 8'h1D; mem[8'h52] = 8'h79;
        mem[8'h53] = 8'h6A; mem[8'h54] = 8'h11; mem[8'h55] = 8'hD0;
        mem[8'h56] = 8'hB0; mem[8'h57] = 8'h60;
        // 60 SUB R2,R1 / 61 JC 70
        mem[8'h60] = 8'h39;
        mem[8'h61] = 8'hC0; mem[8'h62] = 8'h70;
        // 70 AND R3,R0 / 71 OR R3,R2 / 72 JMP FF / FF NOP -> 00 (HALT)
        mem[8'h70] = 8'h4C; mem[8'h71] = 8'h5E;
        mem[8'h72] = 8'hA0; mem[8'h73] = 8'hFF;
        mem[8'hFF] = 8'h00;

        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                      8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                      8'h40, 8'h41, 8'h42, 8'h43, 8'h44,
                      8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57,
                      8'h60, 8'h61, 8'h62,
                      8'h70, 8'h71, 8'h72, 8'h73, 8'hFF, 8'h00};
        exp_wr = '{{2'd1, 8'h05}, {2'd2, 8'h03}, {2'd1, 8'h08},
                   {2'd0, 8'hFF}, {2'd3, 8'h01}, {2'd0, 8'h00},
                   {2'd1, 8'h05}, {2'd3, 8'h05}, {2'd2, 8'hFA}, {2'd2, 8'h00},
                   {2'd0, 8'h05}, {2'd2, 8'hFB}, {2'd3, 8'h05}, {2'd3, 8'hFF}};

        repeat (3) @(negedge clk);
        check_reset("rst_init");

        // Release, sit in FETCH with no memory response, then reset mid-fetch
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midfetch_req", imem_req, 1'b1);
        chk("midfetch_addr", imem_addr, 8'h00);
        rst_n = 1'b0;
        #1;
        check_reset("rst_midfetch");
        @(negedge clk);
        rst_n  = 1'b1;
        mem_en = 1'b1;

        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (halted) done = 1'b1;
        end
        chk("halt_reached", done, 1'b1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("halt_sticky", halted, 1'b1);
            chk("halt_no_req", imem_req, 1'b0);
        end
        chk("fetch_pending", exp_fetch.size(), 0);
        chk("write_pending", exp_wr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
